// File: rtl/kbd_pkg.sv
// kbd_pkg: definitions shared by the PS/2 scan code decoder and its FIFO.
//   kbd_state_e  : decoder FSM states
//   BYTE_*       : protocol byte constants (prefixes and keyboard replies)
//   kbd_event_t  : packed event {make, ext, code[7:0]} stored in the FIFO
//   is_discard() : true for reply/status bytes that never produce an event
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE_ST    = 2'd0,
    EXT_ST     = 2'd1,
    BRK_ST     = 2'd2,
    EXT_BRK_ST = 2'd3
  } kbd_state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] BYTE_F0 = 8'hF0;  // break (release) prefix
  localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] BYTE_EE = 8'hEE;  // echo
  localparam logic [7:0] BYTE_FE = 8'hFE;  // resend request

  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  // Keyboard replies and the error/overrun bytes 00/FF carry no key event.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_EE) ||
           (b == BYTE_FE) || (b == 8'h00)   || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with an extra pointer bit for full/empty.
//   clk, resetN   : clock, asynchronous active-low reset (clears storage too)
//   push, wdata   : write request and data; accepted when not full or when
//                   a pop happens in the same cycle
//   pop           : read request; ignored while empty
//   rdata         : head entry, combinational
//   empty, full   : occupancy flags
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot at the same edge, so a push into a full
  // FIFO is still accepted when paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: turns PS/2 set-2 bytes into make/break key events.
//   clk, resetN        : clock, asynchronous active-low reset
//   din, din_new       : received byte and its one-cycle strobe
//   ev_rd              : pop the FIFO head (ignored while ev_valid=0)
//   ev_valid           : event FIFO not empty
//   ev_code/ext/make   : head event fields, combinational from the FIFO
//   proto_err          : one-cycle pulse on a bad sequence or prefix timeout
//   ovf                : sticky, an event was dropped on a full FIFO
//   state_dbg          : current FSM state
// Optional feature (macro SCANCODE_KEYTABLE_EN): key_query {ext,code} and
// combinational key_down backed by a 512-entry pressed-key table.
module scancode_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  input  logic       ev_rd,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_make,
  output logic       proto_err,
  output logic       ovf,
`ifdef SCANCODE_KEYTABLE_EN
  input  logic [8:0] key_query,
  output logic       key_down,
`endif
  output kbd_state_e state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  kbd_state_e state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          proto_err_q, proto_err_d;
  logic          ovf_q, ovf_d;
  // Decoded events pass through one register stage before the FIFO.
  logic          push_q, push_d;
  kbd_event_t    push_ev_q, push_ev_d;

  kbd_event_t    head_ev;
  logic          fifo_empty, fifo_full, fifo_pop;

  assign state_dbg = state_q;
  assign proto_err = proto_err_q;
  assign ovf       = ovf_q;
  assign ev_valid  = !fifo_empty;
  assign ev_code   = head_ev.code;
  assign ev_ext    = head_ev.ext;
  assign ev_make   = head_ev.make;
  assign fifo_pop  = ev_rd && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    push_ev_d   = '0;
    proto_err_d = 1'b0;
    if (din_new) begin
      unique case (state_q)
        IDLE_ST: begin
          if (din == BYTE_E0)      state_d = EXT_ST;
          else if (din == BYTE_F0) state_d = BRK_ST;
          else if (!is_discard(din)) begin
            push_d    = 1'b1;
            push_ev_d = '{make: 1'b1, ext: 1'b0, code: din};
          end
        end
        EXT_ST: begin
          if (din == BYTE_F0)      state_d = EXT_BRK_ST;
          else if (din != BYTE_E0) begin
            push_d    = 1'b1;
            push_ev_d = '{make: 1'b1, ext: 1'b1, code: din};
            state_d   = IDLE_ST;
          end
        end
        BRK_ST, EXT_BRK_ST: begin
          state_d = IDLE_ST;
          if (din == BYTE_E0 || din == BYTE_F0) begin
            proto_err_d = 1'b1;
          end else begin
            push_d    = 1'b1;
            push_ev_d = '{make: 1'b0, ext: (state_q == EXT_BRK_ST), code: din};
          end
        end
        default: state_d = IDLE_ST;
      endcase
    end else if (state_q != IDLE_ST && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      // A strobe in the same cycle takes the branch above instead.
      state_d     = IDLE_ST;
      proto_err_d = 1'b1;
    end

    // Counter measures the gap since the last byte while a prefix is pending.
    if (din_new || state_q == IDLE_ST || state_d == IDLE_ST) tmo_cnt_d = '0;
    else                                                      tmo_cnt_d = tmo_cnt_q + 1'b1;

    ovf_d = ovf_q | (push_q && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE_ST;
      tmo_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      push_q      <= 1'b0;
      push_ev_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      proto_err_q <= proto_err_d;
      ovf_q       <= ovf_d;
      push_q      <= push_d;
      push_ev_q   <= push_ev_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kbd_event_t))
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push_q),
    .wdata  (push_ev_q),
    .pop    (fifo_pop),
    .rdata  (head_ev),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

`ifdef SCANCODE_KEYTABLE_EN
  logic [511:0] key_tbl_q, key_tbl_d;

  // Tracks key state from every decoded event, even ones the FIFO drops.
  always_comb begin
    key_tbl_d = key_tbl_q;
    if (push_q) key_tbl_d[{push_ev_q.ext, push_ev_q.code}] = push_ev_q.make;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) key_tbl_q <= '0;
    else         key_tbl_q <= key_tbl_d;
  end

  assign key_down = key_tbl_q[key_query];
`endif

endmodule
